// File: rtl/idu_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard.
// Keeps one outstanding-write counter per architectural register. Issue
// increments the counter of the destination, and each write-back port
// decrements it. Decode stalls while a source is still owed a write, or
// while the destination counter cannot take another writer.
module idu_scoreboard #(
    parameter int NR_REG    = 32,
    parameter int RD_W      = 5,
    parameter int CNT_W     = 2,
    parameter int NR_WB     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [RD_W-1:0]        chk_rs1,
    input  logic                   chk_need1,
    input  logic [RD_W-1:0]        chk_rs2,
    input  logic                   chk_need2,
    input  logic [RD_W-1:0]        chk_rd,
    output logic                   stall,
    input  logic                   issue_valid,
    input  logic [NR_WB-1:0]       wb_valid,
    input  logic [NR_WB*RD_W-1:0]  wb_rd,
    output logic [NR_REG-1:0]      busy_mask,
    output logic [RD_W+CNT_W-1:0]  outstanding,
    output logic                   err
);

    localparam int DEC_W = $clog2(NR_WB + 1);
    localparam int OUT_W = RD_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // cnt[0] is reset to zero and its next value is always zero, so x0 never
    // becomes busy.
    logic [NR_REG-1:0][CNT_W-1:0] cnt;
    logic [NR_REG-1:0][CNT_W-1:0] cnt_nxt;
    logic [NR_REG-1:0][DEC_W-1:0] dec;
    logic [NR_REG-1:0]            eff_busy;
    logic [OUT_W-1:0]             sum_nxt;
    logic                         underflow;
    logic                         do_issue;
    logic                         bad_issue;

    // Count how many write-back ports retire a write to each register this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        dec = '0;
        for (int r = 1; r < NR_REG; r++) begin
            for (int i = 0; i < NR_WB; i++) begin
                if (wb_valid[i] && wb_rd[i*RD_W +: RD_W] == RD_W'(r)) begin
                    dec[r] = dec[r] + DEC_W'(1);
                end
            end
        end
    end

    // Decide, per register, whether a reader must still wait. With bypass on,
    // a write retiring this cycle already counts as done.
    always_comb begin
        eff_busy = '0;
        for (int r = 0; r < NR_REG; r++) begin
            if (WB_BYPASS) begin
                eff_busy[r] = int'(cnt[r]) > int'(dec[r]);
            end else begin
                eff_busy[r] = cnt[r] != '0;
            end
        end
    end

    // Form the stall from RAW on either source and from destination
    // saturation; derive the accepted and rejected issue strobes from it.
    always_comb begin
        stall = (chk_need1 && chk_rs1 != '0 && eff_busy[chk_rs1])
             || (chk_need2 && chk_rs2 != '0 && eff_busy[chk_rs2])
             || (chk_rd != '0 && cnt[chk_rd] == CNT_MAX);
        do_issue  = issue_valid && !stall && chk_rd != '0;
        bad_issue = issue_valid && stall;
    end

    // Net each counter's issue and write-back for the next edge, flag
    // underflow, and total the result. A clear drops everything this cycle.
    always_comb begin
        int net;
        net       = 0;
        cnt_nxt   = '0;
        sum_nxt   = '0;
        underflow = 1'b0;
        for (int r = 0; r < NR_REG; r++) begin
            net = int'(cnt[r]) - int'(dec[r]);
            if (do_issue && chk_rd == RD_W'(r)) begin
                net = net + 1;
            end
            if (net < 0) begin
                underflow = 1'b1;
                net       = 0;
            end
            cnt_nxt[r] = CNT_W'(net);
            sum_nxt    = sum_nxt + OUT_W'(cnt_nxt[r]);
        end
        if (clear) begin
            cnt_nxt   = '0;
            sum_nxt   = '0;
            underflow = 1'b0;
        end
    end

    // Register the counters, the running total and the sticky error flag.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment, so every flop samples the values from before the edge.
        if (reset) begin
            // NOTE: the counter array is reset because the stall logic reads it in the first cycle after reset.
            cnt         <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            outstanding <= sum_nxt;
            if (!clear && (underflow || bad_issue)) begin
                err <= 1'b1;
            end
        end
    end

    // Expose which registers have any write outstanding, from registered state only.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NR_REG; r++) begin
            busy_mask[r] = cnt[r] != '0;
        end
    end

endmodule

// File: tb/tb_idu_scoreboard.sv
// Directed self-checking bench for idu_scoreboard with default parameters
// (32 registers, 2-bit counters, 2 write-back ports, bypass enabled).
module tb_idu_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [4:0]  chk_rs1;
    logic        chk_need1;
    logic [4:0]  chk_rs2;
    logic        chk_need2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic        issue_valid;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [31:0] busy_mask;
    logic [6:0]  outstanding;
    logic        err;

    int checks = 0;
    int errors = 0;

    idu_scoreboard dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .chk_rs1     (chk_rs1),
        .chk_need1   (chk_need1),
        .chk_rs2     (chk_rs2),
        .chk_need2   (chk_need2),
        .chk_rd      (chk_rd),
        .stall       (stall),
        .issue_valid (issue_valid),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy_mask   (busy_mask),
        .outstanding (outstanding),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear       = 1'b0;
        chk_rs1     = '0;
        chk_need1   = 1'b0;
        chk_rs2     = '0;
        chk_need2   = 1'b0;
        chk_rd      = '0;
        issue_valid = 1'b0;
        wb_valid    = '0;
        wb_rd       = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        chk_rd      = rd;
        issue_valid = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state.
        chk_rs1 = 5'd5; chk_need1 = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_outst", outstanding, 0);
        check("rst_err", err, 0);

        // Back-to-back dependency on x5, then same-cycle bypass.
        idle(); chk_rd = 5'd5; issue_valid = 1'b1;
        #1 check("iss5_stall", stall, 0);
        tick();
        idle(); chk_rs1 = 5'd5; chk_need1 = 1'b1;
        #1;
        check("raw5_stall", stall, 1);
        check("raw5_busy", busy_mask, 32'h20);
        check("raw5_outst", outstanding, 1);
        idle(); chk_rs2 = 5'd5; chk_need2 = 1'b1;
        #1 check("raw5_rs2", stall, 1);
        chk_need2 = 1'b0;
        #1 check("rs2_notneed", stall, 0);
        idle(); chk_rs1 = 5'd5; chk_need1 = 1'b1; wb_valid = 2'b01; wb_rd = {5'd0, 5'd5};
        #1 check("byp5_stall", stall, 0);
        tick();
        idle(); chk_rs1 = 5'd5; chk_need1 = 1'b1;
        #1;
        check("wb5_busy", busy_mask, 0);
        check("wb5_outst", outstanding, 0);
        check("wb5_stall", stall, 0);

        // Saturate x7.
        for (int k = 0; k < 3; k++) begin
            idle(); chk_rd = 5'd7; issue_valid = 1'b1;
            #1 check("iss7_stall", stall, 0);
            tick();
        end
        idle(); chk_rd = 5'd7;
        #1;
        check("sat7_stall", stall, 1);
        check("sat7_outst", outstanding, 3);
        check("sat7_busy", busy_mask, 32'h80);
        chk_rd = 5'd8;
        #1 check("rd8_stall", stall, 0);

        // Two ports retire two writes to x11 in one cycle: no error.
        issue(5'd11);
        issue(5'd11);
        idle(); chk_rs1 = 5'd11; chk_need1 = 1'b1; wb_valid = 2'b11; wb_rd = {5'd11, 5'd11};
        #1 check("byp11_stall", stall, 0);
        tick();
        idle();
        #1;
        check("wb11_outst", outstanding, 3);
        check("wb11_busy", busy_mask, 32'h80);
        check("wb11_err", err, 0);

        // x9: issue and write-back net to zero change, then underflow.
        issue(5'd9);
        idle(); chk_rd = 5'd9; issue_valid = 1'b1; wb_valid = 2'b01; wb_rd = {5'd0, 5'd9};
        #1 check("net9_stall", stall, 0);
        tick();
        idle();
        #1;
        check("net9_busy", busy_mask, 32'h280);
        check("net9_outst", outstanding, 4);
        check("net9_err", err, 0);
        wb_valid = 2'b11; wb_rd = {5'd9, 5'd9};
        tick();
        idle();
        #1;
        check("uf9_busy", busy_mask, 32'h80);
        check("uf9_outst", outstanding, 3);
        check("uf9_err", err, 1);

        // Clear with a concurrent issue and write-back.
        issue(5'd3);
        issue(5'd4);
        idle();
        #1;
        check("pre_clr_outst", outstanding, 5);
        check("pre_clr_busy", busy_mask, 32'h98);
        clear = 1'b1; chk_rd = 5'd6; issue_valid = 1'b1; wb_valid = 2'b01; wb_rd = {5'd0, 5'd7};
        tick();
        idle(); chk_rs1 = 5'd6; chk_need1 = 1'b1;
        #1;
        check("clr_busy", busy_mask, 0);
        check("clr_outst", outstanding, 0);
        check("clr_err", err, 1);
        check("clr_stall6", stall, 0);

        // Fresh reset; x0 is never tracked.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        idle(); chk_rd = 5'd0; issue_valid = 1'b1; wb_valid = 2'b10; wb_rd = {5'd0, 5'd0};
        tick();
        idle(); chk_rs1 = 5'd0; chk_need1 = 1'b1;
        #1;
        check("x0_stall", stall, 0);
        check("x0_outst", outstanding, 0);
        check("x0_busy", busy_mask, 0);
        check("x0_err", err, 0);

        // Issue while stalled is ignored and flags an error.
        issue(5'd5);
        idle(); chk_rs1 = 5'd5; chk_need1 = 1'b1; chk_rd = 5'd10; issue_valid = 1'b1;
        #1 check("bad_stall", stall, 1);
        tick();
        idle();
        #1;
        check("bad_err", err, 1);
        check("bad_busy", busy_mask, 32'h20);
        check("bad_outst", outstanding, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
